// File: rtl/dr_pkg.sv
// Shared dual-rail rail codes, FSM state type and code classification helper
// for the clocked dual-rail counter ring.
package dr_pkg;

   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_D0   = 2'b01;
   localparam logic [1:0] DR_D1   = 2'b10;
   localparam logic [1:0] DR_ILL  = 2'b11;

   typedef enum logic {
      S_NULL = 1'b0,
      S_DATA = 1'b1
   } dr_state_t;

   function automatic logic dr_is_data(input logic [1:0] code);
      return (code == DR_D0) || (code == DR_D1);
   endfunction

endpackage

// File: rtl/dr_encode.sv
// Binary-to-dual-rail encoder: each bit becomes a rail pair, the whole bus is
// NULL when valid is low so every pair switches together.
module dr_encode
   import dr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   bin,
   input  logic               valid,
   output logic [2*WIDTH-1:0] dr
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign dr[2*gi+1:2*gi] = valid ? (bin[gi] ? DR_D1 : DR_D0) : DR_NULL;
      end
   endgenerate

endmodule

// File: rtl/dr_counter_ring_sync.sv
// Clocked dual-rail counter ring: WIDTH-bit count emitted as DATA/NULL wavefronts.
// Optional parallel load of the count in the NULL phase when DRCNT_LOAD_EN is defined.
module dr_counter_ring_sync
   import dr_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   parameter int               WRAP     = 1
) (
   input  logic               clk,
   input  logic               init,
   input  logic [1:0]         carryin,
   output logic               carryinCOMP,
   output logic [2*WIDTH-1:0] sum,
   input  logic               sumCOMP,
   output logic [1:0]         carryout,
   input  logic               carryoutCOMP,
`ifdef DRCNT_LOAD_EN
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               err
);

   dr_state_t        state_reg, state_next;
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] nxt_reg;
   logic             ovf_reg;
   logic             err_reg;

   logic             ci;
   logic [WIDTH:0]   add_ext;
   logic [WIDTH-1:0] nxt_calc;
   logic             ovf_calc;
   logic             go_data;
   logic             go_null;
   logic             load_now;
   logic             data_valid;

`ifdef DRCNT_LOAD_EN
   assign load_now = (state_reg == S_NULL) && load;
`else
   assign load_now = 1'b0;
`endif

   assign ci      = (carryin == DR_D1);
   assign add_ext = {1'b0, count_reg} + {{WIDTH{1'b0}}, ci};

   // Saturating mode pins the count at all-ones and flags every further increment.
   always_comb begin
      nxt_calc = add_ext[WIDTH-1:0];
      ovf_calc = add_ext[WIDTH];
      if (WRAP == 0 && ci && (&count_reg)) begin
         nxt_calc = count_reg;
         ovf_calc = 1'b1;
      end else if (WRAP == 0) begin
         ovf_calc = 1'b0;
      end
   end

   assign go_data = (state_reg == S_NULL) && !load_now && dr_is_data(carryin)
                    && !sumCOMP && !carryoutCOMP;
   assign go_null = (state_reg == S_DATA) && sumCOMP && carryoutCOMP
                    && (carryin == DR_NULL);

   always_ff @(posedge clk) begin
      if (init) begin
         state_reg <= S_NULL;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_NULL:  if (go_data) state_next = S_DATA;
         S_DATA:  if (go_null) state_next = S_NULL;
         default: state_next = S_NULL;
      endcase
   end

   always_comb begin
      data_valid  = 1'b0;
      carryinCOMP = 1'b0;
      carryout    = DR_NULL;
      if (state_reg == S_DATA) begin
         data_valid  = 1'b1;
         carryinCOMP = 1'b1;
         carryout    = ovf_reg ? DR_D1 : DR_D0;
      end
   end

   // The count commits only on DATA->NULL so a capturing consumer sees it stable.
   always_ff @(posedge clk) begin
      if (init) begin
         count_reg <= INIT_VAL;
         nxt_reg   <= '0;
         ovf_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         if (carryin == DR_ILL) begin
            err_reg <= 1'b1;
         end
         if (go_data) begin
            nxt_reg <= nxt_calc;
            ovf_reg <= ovf_calc;
         end
         if (go_null) begin
            count_reg <= nxt_reg;
         end
`ifdef DRCNT_LOAD_EN
         if (load_now) begin
            count_reg <= load_val;
         end
`endif
      end
   end

   dr_encode #(
      .WIDTH(WIDTH)
   ) u_sum_enc (
      .bin  (nxt_reg),
      .valid(data_valid),
      .dr   (sum)
   );

   assign count = count_reg;
   assign err   = err_reg;

endmodule

// File: tb/tb_dr_counter_ring_sync.sv
// Directed bench: one 32-bit ring plus two 4-bit rings (wrap, saturate) preset to 15,
// all driven by the same handshake stimulus.
module tb_dr_counter_ring_sync;

   logic        clk = 1'b0;
   logic        init;
   logic [1:0]  carryin;
   logic        sumCOMP;
   logic        carryoutCOMP;
   logic        load;
   logic [31:0] load_val;

   logic        cicomp_m, cicomp_w, cicomp_s;
   logic [63:0] sum_m;
   logic [7:0]  sum_w, sum_s;
   logic [1:0]  co_m, co_w, co_s;
   logic [31:0] count_m;
   logic [3:0]  count_w, count_s;
   logic        err_m, err_w, err_s;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   dr_counter_ring_sync #(.WIDTH(32), .INIT_VAL(32'd0), .WRAP(1)) dut_main (
      .clk(clk), .init(init), .carryin(carryin), .carryinCOMP(cicomp_m),
      .sum(sum_m), .sumCOMP(sumCOMP), .carryout(co_m), .carryoutCOMP(carryoutCOMP),
`ifdef DRCNT_LOAD_EN
      .load(load), .load_val(load_val),
`endif
      .count(count_m), .err(err_m)
   );

   dr_counter_ring_sync #(.WIDTH(4), .INIT_VAL(4'hF), .WRAP(1)) dut_wrap (
      .clk(clk), .init(init), .carryin(carryin), .carryinCOMP(cicomp_w),
      .sum(sum_w), .sumCOMP(sumCOMP), .carryout(co_w), .carryoutCOMP(carryoutCOMP),
`ifdef DRCNT_LOAD_EN
      .load(load), .load_val(load_val[3:0]),
`endif
      .count(count_w), .err(err_w)
   );

   dr_counter_ring_sync #(.WIDTH(4), .INIT_VAL(4'hF), .WRAP(0)) dut_sat (
      .clk(clk), .init(init), .carryin(carryin), .carryinCOMP(cicomp_s),
      .sum(sum_s), .sumCOMP(sumCOMP), .carryout(co_s), .carryoutCOMP(carryoutCOMP),
`ifdef DRCNT_LOAD_EN
      .load(load), .load_val(load_val[3:0]),
`endif
      .count(count_s), .err(err_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      carryin = 2'b00; sumCOMP = 1'b0; carryoutCOMP = 1'b0; load = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      init = 1'b1; carryin = 2'b00; sumCOMP = 1'b0; carryoutCOMP = 1'b0;
      load = 1'b0; load_val = '0;
      tick(); tick();
      init = 1'b0;
      total_cnt++;
      if (count_m !== 32'd0 || sum_m !== 64'd0 || co_m !== 2'b00 || cicomp_m !== 1'b0 || err_m !== 1'b0)
         $display("FAIL reset_main: count=%h sum=%h co=%b cicomp=%b err=%b, want 0/0/00/0/0",
                  count_m, sum_m, co_m, cicomp_m, err_m);
      else pass_cnt++;
      total_cnt++;
      if (count_w !== 4'hF || count_s !== 4'hF || sum_w !== 8'h00 || co_s !== 2'b00)
         $display("FAIL reset_small: count_w=%h count_s=%h sum_w=%h co_s=%b, want F/F/00/00",
                  count_w, count_s, sum_w, co_s);
      else pass_cnt++;
      $display("reset: count=%h sum=%h", count_m, sum_m);
   endtask

   task automatic test_increment();
      carryin = 2'b10;
      tick();
      total_cnt++;
      if (sum_m !== 64'h5555_5555_5555_5556 || co_m !== 2'b01 || cicomp_m !== 1'b1 || count_m !== 32'd0)
         $display("FAIL inc_data_main: sum=%h co=%b cicomp=%b count=%h, want 5555555555555556/01/1/0",
                  sum_m, co_m, cicomp_m, count_m);
      else pass_cnt++;
      total_cnt++;
      if (sum_w !== 8'h55 || co_w !== 2'b10)
         $display("FAIL inc_wrap: sum=%h co=%b, want 55/10", sum_w, co_w);
      else pass_cnt++;
      total_cnt++;
      if (sum_s !== 8'hAA || co_s !== 2'b10)
         $display("FAIL inc_sat: sum=%h co=%b, want aa/10", sum_s, co_s);
      else pass_cnt++;
      sumCOMP = 1'b1; carryoutCOMP = 1'b1; carryin = 2'b00;
      tick();
      total_cnt++;
      if (sum_m !== 64'd0 || co_m !== 2'b00 || cicomp_m !== 1'b0 || count_m !== 32'd1)
         $display("FAIL inc_null_main: sum=%h co=%b cicomp=%b count=%h, want 0/00/0/1",
                  sum_m, co_m, cicomp_m, count_m);
      else pass_cnt++;
      total_cnt++;
      if (count_w !== 4'h0 || count_s !== 4'hF)
         $display("FAIL inc_commit_small: count_w=%h count_s=%h, want 0/F", count_w, count_s);
      else pass_cnt++;
      $display("increment: count=%h count_w=%h count_s=%h", count_m, count_w, count_s);
      idle();
   endtask

   task automatic test_hold();
      carryin = 2'b01;
      tick();
      total_cnt++;
      if (sum_m !== 64'h5555_5555_5555_5556 || co_m !== 2'b01 || cicomp_m !== 1'b1)
         $display("FAIL hold_data: sum=%h co=%b cicomp=%b, want 5555555555555556/01/1", sum_m, co_m, cicomp_m);
      else pass_cnt++;
      total_cnt++;
      if (sum_s !== 8'hAA || co_s !== 2'b01 || sum_w !== 8'h55 || co_w !== 2'b01)
         $display("FAIL hold_small: sum_s=%h co_s=%b sum_w=%h co_w=%b, want aa/01/55/01",
                  sum_s, co_s, sum_w, co_w);
      else pass_cnt++;
      sumCOMP = 1'b1; carryoutCOMP = 1'b1; carryin = 2'b00;
      tick();
      total_cnt++;
      if (count_m !== 32'd1 || sum_m !== 64'd0 || count_s !== 4'hF)
         $display("FAIL hold_null: count=%h sum=%h count_s=%h, want 1/0/F", count_m, sum_m, count_s);
      else pass_cnt++;
      $display("hold: count=%h", count_m);
      idle();
   endtask

   task automatic test_stall();
      // Consumer still completed from before: DATA must wait.
      carryin = 2'b10; sumCOMP = 1'b1;
      tick();
      total_cnt++;
      if (cicomp_m !== 1'b0 || sum_m !== 64'd0)
         $display("FAIL stall_comp_high: cicomp=%b sum=%h, want 0/0", cicomp_m, sum_m);
      else pass_cnt++;
      sumCOMP = 1'b0;
      tick();
      total_cnt++;
      if (cicomp_m !== 1'b1 || sum_m !== 64'h5555_5555_5555_5559)
         $display("FAIL stall_data: cicomp=%b sum=%h, want 1/5555555555555559", cicomp_m, sum_m);
      else pass_cnt++;
      carryin = 2'b00; carryoutCOMP = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total_cnt++;
         if (sum_m !== 64'h5555_5555_5555_5559 || cicomp_m !== 1'b1 || count_m !== 32'd1)
            $display("FAIL stall_hold_%0d: sum=%h cicomp=%b count=%h, want 5555555555555559/1/1",
                     i, sum_m, cicomp_m, count_m);
         else pass_cnt++;
      end
      sumCOMP = 1'b1;
      tick();
      total_cnt++;
      if (sum_m !== 64'd0 || cicomp_m !== 1'b0 || count_m !== 32'd2)
         $display("FAIL stall_release: sum=%h cicomp=%b count=%h, want 0/0/2", sum_m, cicomp_m, count_m);
      else pass_cnt++;
      $display("stall: count=%h", count_m);
      idle();
   endtask

   task automatic test_illegal();
      carryin = 2'b11;
      tick();
      total_cnt++;
      if (err_m !== 1'b1 || cicomp_m !== 1'b0 || sum_m !== 64'd0)
         $display("FAIL ill_null: err=%b cicomp=%b sum=%h, want 1/0/0", err_m, cicomp_m, sum_m);
      else pass_cnt++;
      carryin = 2'b10;
      tick();
      total_cnt++;
      if (cicomp_m !== 1'b1 || sum_m !== 64'h5555_5555_5555_555A || err_m !== 1'b1)
         $display("FAIL ill_then_data: cicomp=%b sum=%h err=%b, want 1/555555555555555a/1", cicomp_m, sum_m, err_m);
      else pass_cnt++;
      sumCOMP = 1'b1; carryoutCOMP = 1'b1; carryin = 2'b11;
      tick();
      total_cnt++;
      if (cicomp_m !== 1'b1 || count_m !== 32'd2)
         $display("FAIL ill_not_null: cicomp=%b count=%h, want 1/2", cicomp_m, count_m);
      else pass_cnt++;
      carryin = 2'b00;
      tick();
      total_cnt++;
      if (cicomp_m !== 1'b0 || count_m !== 32'd3 || err_m !== 1'b1)
         $display("FAIL ill_commit: cicomp=%b count=%h err=%b, want 0/3/1", cicomp_m, count_m, err_m);
      else pass_cnt++;
      idle();
      init = 1'b1;
      tick();
      init = 1'b0;
      total_cnt++;
      if (err_m !== 1'b0 || count_m !== 32'd0)
         $display("FAIL ill_init_clear: err=%b count=%h, want 0/0", err_m, count_m);
      else pass_cnt++;
      $display("illegal: err=%b count=%h", err_m, count_m);
   endtask

   task automatic test_init_midflight();
      carryin = 2'b10;
      tick();
      sumCOMP = 1'b1; carryoutCOMP = 1'b1; carryin = 2'b00; init = 1'b1;
      tick();
      init = 1'b0;
      total_cnt++;
      if (count_m !== 32'd0 || sum_m !== 64'd0 || cicomp_m !== 1'b0 || co_m !== 2'b00 || count_w !== 4'hF)
         $display("FAIL init_mid: count=%h sum=%h cicomp=%b co=%b count_w=%h, want 0/0/0/00/F",
                  count_m, sum_m, cicomp_m, co_m, count_w);
      else pass_cnt++;
      $display("init_midflight: count=%h", count_m);
      idle();
   endtask

`ifdef DRCNT_LOAD_EN
   task automatic test_load();
      load = 1'b1; load_val = 32'hA; carryin = 2'b10;
      tick();
      total_cnt++;
      if (count_m !== 32'hA || cicomp_m !== 1'b0 || sum_m !== 64'd0)
         $display("FAIL load: count=%h cicomp=%b sum=%h, want a/0/0", count_m, cicomp_m, sum_m);
      else pass_cnt++;
      load = 1'b0;
      tick();
      total_cnt++;
      if (cicomp_m !== 1'b1 || sum_m !== 64'h5555_5555_5555_559A)
         $display("FAIL load_then_data: cicomp=%b sum=%h, want 1/555555555555559a", cicomp_m, sum_m);
      else pass_cnt++;
      sumCOMP = 1'b1; carryoutCOMP = 1'b1; carryin = 2'b00;
      tick();
      total_cnt++;
      if (count_m !== 32'hB)
         $display("FAIL load_commit: count=%h, want b", count_m);
      else pass_cnt++;
      $display("load: count=%h", count_m);
      idle();
   endtask
`endif

   initial begin
      test_reset();
      test_increment();
      test_hold();
      test_stall();
      test_illegal();
      test_init_midflight();
`ifdef DRCNT_LOAD_EN
      test_load();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dr_counter_ring_sync.md
Name: dr_counter_ring_sync

Overview:
Clocked, parametrised successor to the 2-bit dual-rail counter ring.
- Holds a WIDTH-bit count and presents it as a dual-rail (NCL-encoded) bus with DATA/NULL wavefront alternation.
- Handshakes with neighbouring dual-rail logic through completeness (COMP) signals.
- Sits at the boundary between the clocked domain and NCL pipelines, as a wide counter source or for counter-chain testbenches.

Parameters:
WIDTH, 32, number of count bits (dual-rail output width is 2*WIDTH)
INIT_VAL, 0, count value loaded on reset
WRAP, 1, 1 = modulo-2^WIDTH wrap; 0 = saturate at all-ones

Ports:
clk  in  1  single clock
init  in  1  synchronous active-high reset
carryin  in  2  dual-rail increment request: 00 = NULL, 01 = DATA0 (hold), 10 = DATA1 (+1), 11 = illegal
carryinCOMP  out  1  completeness to carryin producer; 1 = DATA accepted, 0 = NULL accepted
sum  out  2*WIDTH  dual-rail count; bit i on sum[2i+1:2i]; rail0 = DATA0, rail1 = DATA1
sumCOMP  in  1  completeness from sum consumer
carryout  out  2  dual-rail overflow/saturation flag
carryoutCOMP  in  1  completeness from carryout consumer
count  out  WIDTH  binary committed count, for observation
err  out  1  sticky illegal-code flag

Behaviour:
- Reset (init = 1 at a clk edge):
  - count = INIT_VAL; sum = all-zero (NULL); carryout = 00; carryinCOMP = 0; err = 0; state = S_NULL.
  - Reset applied mid-handshake abandons the wavefront with no commit.
- FSM, two states:
  - S_NULL: sum and carryout are NULL, carryinCOMP = 0.
    - Advance when carryin is legal DATA (01 or 10), sumCOMP = 0 and carryoutCOMP = 0.
    - Compute nxt = count + ci (ci = 1 for 10).
    - Next cycle: sum = dual-rail(nxt), carryout = overflow ? 10 : 01, carryinCOMP = 1, state = S_DATA.
  - S_DATA: outputs held stable.
    - Advance when sumCOMP = 1, carryoutCOMP = 1 and carryin = 00.
    - Next cycle: count = nxt, sum = NULL, carryout = 00, carryinCOMP = 0, state = S_NULL.
- Latency: 1 clk from the qualifying condition to output change, in both phases.
- Every bit of sum transitions in the same cycle; no partial DATA or partial NULL is ever visible.
- Arithmetic:
  - WRAP = 1: nxt = (count + ci) mod 2^WIDTH; overflow = carry out of the MSB.
  - WRAP = 0: at all-ones with ci = 1, nxt stays all-ones and overflow = 1; otherwise overflow = 0.
  - ci = 0 gives nxt = count and overflow = 0.
- Boundary conditions:
  - carryin = 11 in S_NULL: ignored (stays in S_NULL) and err is set. err is cleared only by init.
  - carryin = 11 in S_DATA: err is set, and the 11 does not count as NULL.
  - COMP already high while in S_NULL (consumer not yet nulled): block waits.
  - carryin returning to NULL before the consumers complete: block waits for all three conditions together.
  - Conditions may arrive in any order or on the same cycle.
- count updates only on the DATA-to-NULL transition, so a consumer that is still capturing never sees the count change.

Optional Feature:
DRCNT_LOAD_EN
- Defined: adds ports load (in, 1) and load_val (in, WIDTH).
  - In S_NULL with load = 1: count = load_val next cycle and no wavefront is emitted.
  - load has priority over a simultaneous DATA carryin, which is then taken on the following cycle if still present.
  - load is ignored in S_DATA.
- Undefined: ports absent; count changes only via increment or init.

Decomposition:
- Package dr_pkg:
  - rail constants DR_NULL = 2'b00, DR_D0 = 2'b01, DR_D1 = 2'b10, DR_ILL = 2'b11;
  - state enum {S_NULL, S_DATA};
  - function dr_is_data(code).
- Sub-module dr_encode #(WIDTH): binary plus valid in, dual-rail bus out; emits NULL when valid = 0. Used for sum; carryout is encoded inline.

Test Plan:
- Reset, then with INIT_VAL = 0 drive one full handshake with carryin = 10 -> sum encodes 1 (sum[1:0] = 10, all higher pairs = 01), carryout = 01, carryinCOMP = 1; after COMPs go high and carryin = 00 -> NULL, count = 1.
- carryin = 01 (hold) wavefront -> sum equals the current count, count unchanged after NULL, carryout = 01.
- WIDTH = 4, WRAP = 1, count = 15, increment -> sum = 0, carryout = 10; WRAP = 0 -> sum = 15, carryout = 10.
- Hold sumCOMP = 0 for 10 cycles in S_DATA while carryoutCOMP = 1 and carryin = 00 -> outputs stable and no commit; NULL appears 1 cycle after sumCOMP rises.
- carryin = 11 in S_NULL -> err = 1, no state change; a later legal DATA still proceeds; init clears err.
- Assert init while in S_DATA with an increment pending -> next cycle count = INIT_VAL, outputs NULL, carryinCOMP = 0. With DRCNT_LOAD_EN defined: load = 1, load_val = 0xA in S_NULL -> count = 0xA and no wavefront.
